// File: rtl/stage_memory.sv
// -----------------------------------------------------------------------------
// stage_memory
//   Pipeline stage between execute and writeback. Non-memory instructions pass
//   their ALU result through with one cycle of latency. RV32I loads and stores
//   are issued on the data-memory bus with a req/ack handshake. Upstream stages
//   are stalled while an access is outstanding. A bus fault is reported if the
//   ack does not arrive within TIMEOUT_CYCLES access cycles.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   execute_*             registered outputs of the execute stage
//   memory_stall          upstream must hold its outputs this cycle
//   dmem_req/we/addr/be/wdata, dmem_ack/rdata
//                         data-memory bus (word-aligned, lane-replicated data)
//   memory_valid/rd/wr_enable/result
//                         writeback outputs, memory_valid pulses once per instr
//   memory_fault          one-cycle pulse: misaligned, illegal funct3, timeout
// -----------------------------------------------------------------------------
module stage_memory #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        execute_valid,
    input  logic [31:0] execute_alu_result,
    input  logic [4:0]  execute_rd,
    input  logic        execute_wr_enable,
    input  logic        execute_mem_to_reg,
    input  logic        execute_mem_write,
    input  logic [2:0]  execute_funct3,
    input  logic [31:0] execute_store_data,
    output logic        memory_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        memory_valid,
    output logic [4:0]  memory_rd,
    output logic        memory_wr_enable,
    output logic [31:0] memory_result,
    output logic        memory_fault
);

    typedef enum logic {IDLE, ACCESS} state_t;

    // Last counter value before abort: the abort fires on the cycle in which
    // the count of ack-less access cycles reaches TIMEOUT_CYCLES.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  tmo_cnt;

    // Access context captured when a request is launched.
    logic [4:0]  rd_p0;
    logic [2:0]  funct3_p0;
    logic [1:0]  addr_lo_p0;
    logic        is_load_p0;
    logic        wr_en_p0;

    logic        is_mem;
    logic        f3_ok;
    logic        aligned;
    logic        launch;

    // Byte enables for a store, shifted to the addressed lane.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = 4'b0011 << off;
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Store data replicated across lanes so the bus picks it up via byte enables.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_wdata = {4{d[7:0]}};
            2'b01:   store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

    // Byte/half selection and sign/zero extension of a loaded word.
    function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] off,
                                                 input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        case (off)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'd0, b};
            3'b101:  load_extract = {16'd0, h};
            default: load_extract = w;
        endcase
    endfunction

    always_comb begin
        is_mem  = execute_mem_to_reg | execute_mem_write;
        f3_ok   = 1'b0;
        aligned = 1'b1;
        if (execute_mem_to_reg) begin
            f3_ok = (execute_funct3 == 3'b000) || (execute_funct3 == 3'b001) ||
                    (execute_funct3 == 3'b010) || (execute_funct3 == 3'b100) ||
                    (execute_funct3 == 3'b101);
        end else begin
            f3_ok = (execute_funct3 == 3'b000) || (execute_funct3 == 3'b001) ||
                    (execute_funct3 == 3'b010);
        end
        // funct3[1:0] encodes width for both loads and stores.
        case (execute_funct3[1:0])
            2'b01:   aligned = ~execute_alu_result[0];
            2'b10:   aligned = (execute_alu_result[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
        launch = (state == IDLE) && execute_valid && is_mem && f3_ok && aligned;
    end

    // Stall is derived from the registered state, so it falls in the cycle
    // after ack and upstream advances exactly once per memory instruction.
    assign memory_stall = (state == ACCESS);

    // ---- stage boundary: access context capture ----
    always_ff @(posedge clk) begin
        if (launch) begin
            rd_p0      <= execute_rd;
            funct3_p0  <= execute_funct3;
            addr_lo_p0 <= execute_alu_result[1:0];
            is_load_p0 <= execute_mem_to_reg;
            wr_en_p0   <= execute_wr_enable;
        end
    end

    // ---- stage boundary: control, bus and writeback registers ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            tmo_cnt          <= 8'd0;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= 32'd0;
            dmem_be          <= 4'd0;
            dmem_wdata       <= 32'd0;
            memory_valid     <= 1'b0;
            memory_rd        <= 5'd0;
            memory_wr_enable <= 1'b0;
            memory_result    <= 32'd0;
            memory_fault     <= 1'b0;
        end else begin
            memory_valid     <= 1'b0;
            memory_fault     <= 1'b0;
            memory_wr_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (execute_valid) begin
                        if (!is_mem) begin
                            memory_valid     <= 1'b1;
                            memory_rd        <= execute_rd;
                            memory_wr_enable <= execute_wr_enable;
                            memory_result    <= execute_alu_result;
                        end else if (!launch) begin
                            // Misaligned or illegal width: report without bus traffic.
                            memory_valid  <= 1'b1;
                            memory_fault  <= 1'b1;
                            memory_rd     <= execute_rd;
                            memory_result <= 32'd0;
                        end else begin
                            state      <= ACCESS;
                            tmo_cnt    <= 8'd0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= execute_mem_write & ~execute_mem_to_reg;
                            dmem_addr  <= {execute_alu_result[31:2], 2'b00};
                            if (execute_mem_to_reg) begin
                                dmem_be    <= 4'b1111;
                                dmem_wdata <= 32'd0;
                            end else begin
                                dmem_be    <= store_be(execute_funct3, execute_alu_result[1:0]);
                                dmem_wdata <= store_wdata(execute_funct3, execute_store_data);
                            end
                        end
                    end
                end
                ACCESS: begin
                    // Ack takes priority over a timeout in the same cycle.
                    if (dmem_ack) begin
                        state            <= IDLE;
                        tmo_cnt          <= 8'd0;
                        dmem_req         <= 1'b0;
                        memory_valid     <= 1'b1;
                        memory_rd        <= rd_p0;
                        memory_wr_enable <= is_load_p0 & wr_en_p0;
                        memory_result    <= is_load_p0 ?
                                            load_extract(funct3_p0, addr_lo_p0, dmem_rdata) : 32'd0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state         <= IDLE;
                        tmo_cnt       <= 8'd0;
                        dmem_req      <= 1'b0;
                        memory_valid  <= 1'b1;
                        memory_fault  <= 1'b1;
                        memory_rd     <= rd_p0;
                        memory_result <= 32'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stage_memory.sv
module tb_stage_memory;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        execute_valid;
    logic [31:0] execute_alu_result;
    logic [4:0]  execute_rd;
    logic        execute_wr_enable;
    logic        execute_mem_to_reg;
    logic        execute_mem_write;
    logic [2:0]  execute_funct3;
    logic [31:0] execute_store_data;
    logic        memory_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        memory_valid;
    logic [4:0]  memory_rd;
    logic        memory_wr_enable;
    logic [31:0] memory_result;
    logic        memory_fault;

    stage_memory #(.TIMEOUT_CYCLES(4)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .execute_valid      (execute_valid),
        .execute_alu_result (execute_alu_result),
        .execute_rd         (execute_rd),
        .execute_wr_enable  (execute_wr_enable),
        .execute_mem_to_reg (execute_mem_to_reg),
        .execute_mem_write  (execute_mem_write),
        .execute_funct3     (execute_funct3),
        .execute_store_data (execute_store_data),
        .memory_stall       (memory_stall),
        .dmem_req           (dmem_req),
        .dmem_we            (dmem_we),
        .dmem_addr          (dmem_addr),
        .dmem_be            (dmem_be),
        .dmem_wdata         (dmem_wdata),
        .dmem_ack           (dmem_ack),
        .dmem_rdata         (dmem_rdata),
        .memory_valid       (memory_valid),
        .memory_rd          (memory_rd),
        .memory_wr_enable   (memory_wr_enable),
        .memory_result      (memory_result),
        .memory_fault       (memory_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        wr;
        logic [31:0] res;
        logic        fault;
        logic        chk_res;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: pops one expectation per writeback pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            check("fault_only_with_valid", {31'd0, memory_fault & ~memory_valid}, 32'd0);
            if (memory_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got rd=%0d result=%h expected no completion",
                             memory_rd, memory_result);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("wb_rd", {27'd0, memory_rd}, {27'd0, e.rd});
                    check("wb_wr_enable", {31'd0, memory_wr_enable}, {31'd0, e.wr});
                    check("wb_fault", {31'd0, memory_fault}, {31'd0, e.fault});
                    if (e.chk_res) check("wb_result", memory_result, e.res);
                end
            end
        end
    end

    task automatic issue(input logic [31:0] alu, input logic [4:0] rd, input logic wr,
                         input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] sd);
        execute_valid      = 1'b1;
        execute_alu_result = alu;
        execute_rd         = rd;
        execute_wr_enable  = wr;
        execute_mem_to_reg = ld;
        execute_mem_write  = st;
        execute_funct3     = f3;
        execute_store_data = sd;
        @(posedge clk);
        #1;
        execute_valid      = 1'b0;
        execute_mem_to_reg = 1'b0;
        execute_mem_write  = 1'b0;
    endtask

    task automatic alu_op(input logic [31:0] alu, input logic [4:0] rd, input logic wr);
        exp_t e;
        e = '{rd: rd, wr: wr, res: alu, fault: 1'b0, chk_res: 1'b1};
        exp_q.push_back(e);
        issue(alu, rd, wr, 1'b0, 1'b0, 3'b000, 32'd0);
        check("alu_no_stall", {31'd0, memory_stall}, 32'd0);
        check("alu_no_req", {31'd0, dmem_req}, 32'd0);
    endtask

    task automatic mem_op(input logic [31:0] addr, input logic [2:0] f3, input logic st,
                          input logic [31:0] sd, input logic [4:0] rd, input logic wr,
                          input int delay, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_res);
        exp_t e;
        e = '{rd: rd, wr: st ? 1'b0 : wr, res: exp_res, fault: 1'b0, chk_res: ~st};
        exp_q.push_back(e);
        issue(addr, rd, wr, ~st, st, f3, sd);
        check("bus_addr", dmem_addr, exp_addr);
        check("bus_be", {28'd0, dmem_be}, {28'd0, exp_be});
        check("bus_we", {31'd0, dmem_we}, {31'd0, st});
        check("bus_wdata", dmem_wdata, exp_wdata);
        for (int i = 0; i < delay; i++) begin
            check("access_stall", {31'd0, memory_stall}, 32'd1);
            check("access_req", {31'd0, dmem_req}, 32'd1);
            check("access_addr_held", dmem_addr, exp_addr);
            if (i == delay - 1) begin
                dmem_ack   = 1'b1;
                dmem_rdata = rdata;
            end
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
        end
        check("done_stall", {31'd0, memory_stall}, 32'd0);
        check("done_req", {31'd0, dmem_req}, 32'd0);
    endtask

    task automatic fault_op(input logic [31:0] addr, input logic [2:0] f3, input logic st,
                            input logic [4:0] rd);
        exp_t e;
        e = '{rd: rd, wr: 1'b0, res: 32'd0, fault: 1'b1, chk_res: 1'b0};
        exp_q.push_back(e);
        issue(addr, rd, 1'b1, ~st, st, f3, 32'h1111_2222);
        check("fault_no_req", {31'd0, dmem_req}, 32'd0);
        check("fault_no_stall", {31'd0, memory_stall}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, {31'd0, dmem_req}, 32'd0);
        check({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
        check({tag, "_addr"}, dmem_addr, 32'd0);
        check({tag, "_be"}, {28'd0, dmem_be}, 32'd0);
        check({tag, "_wdata"}, dmem_wdata, 32'd0);
        check({tag, "_stall"}, {31'd0, memory_stall}, 32'd0);
        check({tag, "_valid"}, {31'd0, memory_valid}, 32'd0);
        check({tag, "_rd"}, {27'd0, memory_rd}, 32'd0);
        check({tag, "_wr"}, {31'd0, memory_wr_enable}, 32'd0);
        check({tag, "_result"}, memory_result, 32'd0);
        check({tag, "_fault"}, {31'd0, memory_fault}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        execute_valid = 1'b0;
        execute_alu_result = 32'd0;
        execute_rd = 5'd0;
        execute_wr_enable = 1'b0;
        execute_mem_to_reg = 1'b0;
        execute_mem_write = 1'b0;
        execute_funct3 = 3'd0;
        execute_store_data = 32'd0;
        dmem_ack = 1'b0;
        dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ALU passthrough
        alu_op(32'h0000_1234, 5'd5, 1'b1);
        alu_op(32'hDEAD_BEEF, 5'd9, 1'b0);
        @(posedge clk);
        #1;

        // Loads: LB, then back-to-back LBU, LH, LHU, LW
        mem_op(32'h0000_1003, 3'b000, 1'b0, 32'd0, 5'd7, 1'b1, 3, 32'h80AA_BBCC,
               32'h0000_1000, 4'b1111, 32'd0, 32'hFFFF_FF80);
        mem_op(32'h0000_1001, 3'b100, 1'b0, 32'd0, 5'd8, 1'b1, 1, 32'h80AA_BBCC,
               32'h0000_1000, 4'b1111, 32'd0, 32'h0000_00BB);
        mem_op(32'h0000_1002, 3'b001, 1'b0, 32'd0, 5'd10, 1'b1, 2, 32'h80AA_BBCC,
               32'h0000_1000, 4'b1111, 32'd0, 32'hFFFF_80AA);
        mem_op(32'h0000_1000, 3'b101, 1'b0, 32'd0, 5'd11, 1'b1, 1, 32'h80AA_BBCC,
               32'h0000_1000, 4'b1111, 32'd0, 32'h0000_BBCC);
        mem_op(32'h0000_1004, 3'b010, 1'b0, 32'd0, 5'd12, 1'b1, 2, 32'h1234_5678,
               32'h0000_1004, 4'b1111, 32'd0, 32'h1234_5678);
        alu_op(32'h0000_00AB, 5'd13, 1'b1);

        // Stores: SH upper half, SB lane 1, SW
        mem_op(32'h0000_2002, 3'b001, 1'b1, 32'h0000_BEEF, 5'd14, 1'b1, 1, 32'd0,
               32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 32'd0);
        mem_op(32'h0000_2001, 3'b000, 1'b1, 32'h1234_56A5, 5'd15, 1'b1, 2, 32'd0,
               32'h0000_2000, 4'b0010, 32'hA5A5_A5A5, 32'd0);
        mem_op(32'h0000_2008, 3'b010, 1'b1, 32'hCAFE_F00D, 5'd16, 1'b0, 1, 32'd0,
               32'h0000_2008, 4'b1111, 32'hCAFE_F00D, 32'd0);

        // Misaligned and illegal encodings
        fault_op(32'h0000_3001, 3'b010, 1'b0, 5'd17);
        fault_op(32'h0000_3003, 3'b101, 1'b0, 5'd18);
        fault_op(32'h0000_3000, 3'b011, 1'b0, 5'd19);
        fault_op(32'h0000_3000, 3'b100, 1'b1, 5'd20);
        @(posedge clk);
        #1;

        // Bus timeout after 4 ack-less access cycles
        begin
            exp_t e;
            e = '{rd: 5'd4, wr: 1'b0, res: 32'd0, fault: 1'b1, chk_res: 1'b0};
            exp_q.push_back(e);
            issue(32'h0000_5000, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 32'd0);
            for (int i = 0; i < 4; i++) begin
                check("tmo_req_held", {31'd0, dmem_req}, 32'd1);
                check("tmo_stall", {31'd0, memory_stall}, 32'd1);
                @(posedge clk);
                #1;
            end
            check("tmo_req_dropped", {31'd0, dmem_req}, 32'd0);
            check("tmo_stall_released", {31'd0, memory_stall}, 32'd0);
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of an access, late ack afterwards
        issue(32'h0000_4000, 5'd3, 1'b1, 1'b1, 1'b0, 3'b010, 32'd0);
        check("pre_reset_req", {31'd0, dmem_req}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        check("late_ack_req", {31'd0, dmem_req}, 32'd0);
        check("late_ack_stall", {31'd0, memory_stall}, 32'd0);
        check("late_ack_valid", {31'd0, memory_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("late_ack_valid2", {31'd0, memory_valid}, 32'd0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
